// File: rtl/datapath_sequencer_if.sv
// Instruction handshake between the issuing unit and the datapath sequencer.
interface datapath_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 7
);
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   op_code;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;

  modport master (output instr_valid, op_code, rs1, rs2, rd, input instr_ready);
  modport slave  (input instr_valid, op_code, rs1, rs2, rd, output instr_ready);
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit driving register file, data memory and
// adder_subtractor control/address lines, one instruction at a time.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for an instruction, instr_ready high
// READ_RF     | register file read ports addressed (store, add, sub)
// EXECUTE     | ALU operation selected, read addresses held
// MEM_WRITE   | store: rf[rs1] written to mem[rd]
// MEM_READ    | load: mem[rs1] read requested
// WRITEBACK   | register file written from ALU or memory
// DONE        | one-cycle completion pulse, illegal_op flagged here
module datapath_sequencer #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  datapath_sequencer_if.slave instr,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [1:0]        rf_wdata_sel,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_write_enable,
  output logic              dm_read,
  output logic              alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_RF, S_EXECUTE, S_MEM_WRITE, S_MEM_READ, S_WRITEBACK, S_DONE
  } state_t;

  localparam logic [OP_W-1:0] OP_NONE  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(4);

  state_t            state, state_nxt;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic              err_q;
  logic              accept;
  logic              is_arith;

  assign accept            = instr.instr_valid && (state == S_IDLE);
  assign instr.instr_ready = (state == S_IDLE);
  assign is_arith          = (op_q == OP_ADD) || (op_q == OP_SUB);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Capture instruction fields only at the accept edge; ignored while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= instr.op_code;
      rs1_q <= instr.rs1;
      rs2_q <= instr.rs2;
      rd_q  <= instr.rd;
      err_q <= (instr.op_code > OP_LOAD);
    end
  end

  // Retired-instruction counter, bumped as a legal instruction leaves DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        retired_count <= '0;
    else if (state == S_DONE && !err_q) retired_count <= retired_count + CNT_W'(1);
  end

  // Next-state and Moore output decode from state and latched fields.
  always_comb begin
    state_nxt       = state;
    rf_addr_a       = '0;
    rf_addr_b       = '0;
    rf_write_en     = 1'b0;
    rf_write_addr   = '0;
    rf_wdata_sel    = 2'd0;
    dm_addr         = '0;
    dm_write_enable = 1'b0;
    dm_read         = 1'b0;
    alu_op          = 1'b0;
    busy            = (state != S_IDLE);
    done            = 1'b0;
    illegal_op      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (instr.op_code)
            OP_NONE:                  state_nxt = S_IDLE;
            OP_STORE, OP_ADD, OP_SUB: state_nxt = S_READ_RF;
            OP_LOAD:                  state_nxt = S_MEM_READ;
            default:                  state_nxt = S_DONE;
          endcase
        end
      end
      S_READ_RF: begin
        rf_addr_a = rs1_q;
        if (is_arith) rf_addr_b = rs2_q;
        state_nxt = (op_q == OP_STORE) ? S_MEM_WRITE : S_EXECUTE;
      end
      S_EXECUTE: begin
        rf_addr_a = rs1_q;
        rf_addr_b = rs2_q;
        alu_op    = (op_q == OP_SUB);
        state_nxt = S_WRITEBACK;
      end
      S_MEM_WRITE: begin
        rf_addr_a       = rs1_q;
        dm_addr         = rd_q;
        dm_write_enable = 1'b1;
        state_nxt       = S_DONE;
      end
      S_MEM_READ: begin
        dm_addr   = rs1_q;
        dm_read   = 1'b1;
        state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rf_write_en   = 1'b1;
        rf_write_addr = rd_q;
        if (is_arith) begin
          rf_addr_a    = rs1_q;
          rf_addr_b    = rs2_q;
          alu_op       = (op_q == OP_SUB);
          rf_wdata_sel = 2'd1;
        end else begin
          dm_addr      = rs1_q;
          dm_read      = 1'b1;
          rf_wdata_sel = 2'd2;
        end
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        illegal_op = err_q;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: instruction table plus reset-abort
// and counter-wrap sequences.
module tb_datapath_sequencer;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic       we;
    logic [4:0] wa;
    logic [1:0] sel;
    logic [4:0] dma;
    logic       dwe;
    logic       drd;
    logic       alu;
    logic       bsy;
    logic       dn;
    logic       ill;
  } ctrl_t;

  typedef struct {
    logic [6:0]      op;
    logic [4:0]      rs1, rs2, rd;
    int              lat;
    int              legal;
    ctrl_t [1:4]     exp;
  } vec_t;

  localparam int NV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_count = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  datapath_sequencer_if #(.ADDR_W(5), .OP_W(7)) dsi ();
  datapath_sequencer_if #(.ADDR_W(5), .OP_W(7)) wsi ();

  logic [4:0]  rf_addr_a, rf_addr_b, rf_write_addr, dm_addr;
  logic [1:0]  rf_wdata_sel;
  logic        rf_write_en, dm_write_enable, dm_read, alu_op, busy, done, illegal_op;
  logic [15:0] retired_count;

  datapath_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(dsi.slave),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_write_en(rf_write_en),
    .rf_write_addr(rf_write_addr), .rf_wdata_sel(rf_wdata_sel), .dm_addr(dm_addr),
    .dm_write_enable(dm_write_enable), .dm_read(dm_read), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal_op(illegal_op), .retired_count(retired_count)
  );

  logic [4:0] w_a, w_b, w_wa, w_dma;
  logic [1:0] w_sel, w_count;
  logic       w_we, w_dwe, w_drd, w_alu, w_busy, w_done, w_ill;

  datapath_sequencer #(.CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .instr(wsi.slave),
    .rf_addr_a(w_a), .rf_addr_b(w_b), .rf_write_en(w_we),
    .rf_write_addr(w_wa), .rf_wdata_sel(w_sel), .dm_addr(w_dma),
    .dm_write_enable(w_dwe), .dm_read(w_drd), .alu_op(w_alu),
    .busy(w_busy), .done(w_done), .illegal_op(w_ill), .retired_count(w_count)
  );

  ctrl_t act;
  assign act = {rf_addr_a, rf_addr_b, rf_write_en, rf_write_addr, rf_wdata_sel,
                dm_addr, dm_write_enable, dm_read, alu_op, busy, done, illegal_op};

  function automatic ctrl_t cw(input logic [4:0] a, input logic [4:0] b, input logic we,
                               input logic [4:0] wa, input logic [1:0] sel,
                               input logic [4:0] dma, input logic dwe, input logic drd,
                               input logic alu, input logic dn, input logic ill);
    cw = {a, b, we, wa, sel, dma, dwe, drd, alu, 1'b1, dn, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic set_vec(input int i, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input int lat,
                         input int legal);
    vecs[i].op = op; vecs[i].rs1 = rs1; vecs[i].rs2 = rs2; vecs[i].rd = rd;
    vecs[i].lat = lat; vecs[i].legal = legal; vecs[i].exp = '0;
  endtask

  task automatic drive(input int i);
    if (i < NV) begin
      dsi.instr_valid = 1'b1;
      dsi.op_code = vecs[i].op;
      dsi.rs1 = vecs[i].rs1;
      dsi.rs2 = vecs[i].rs2;
      dsi.rd  = vecs[i].rd;
    end else begin
      dsi.instr_valid = 1'b0;
    end
  endtask

  // Write enables: never together, never two cycles in a row.
  logic prev_we = 1'b0, prev_dwe = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if ((rf_write_en && dm_write_enable) || (rf_write_en && prev_we) ||
          (dm_write_enable && prev_dwe)) begin
        fails++;
        $display("FAIL write_pulse: we=%b dwe=%b prev_we=%b prev_dwe=%b required single exclusive pulses",
                 rf_write_en, dm_write_enable, prev_we, prev_dwe);
      end
    end
    prev_we  = rf_write_en;
    prev_dwe = dm_write_enable;
  end

  initial begin
    // add, store, sub, load, illegal 7F, none, add to rd=0, illegal 5
    set_vec(0, 7'd2, 5'd2, 5'd3, 5'd10, 4, 1);
    vecs[0].exp[1] = cw(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0].exp[2] = cw(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0].exp[3] = cw(2, 3, 1, 10, 1, 0, 0, 0, 0, 0, 0);
    vecs[0].exp[4] = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    set_vec(1, 7'd1, 5'd4, 5'd6, 5'd7, 3, 1);
    vecs[1].exp[1] = cw(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1].exp[2] = cw(4, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    vecs[1].exp[3] = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    set_vec(2, 7'd3, 5'd4, 5'd5, 5'd14, 4, 1);
    vecs[2].exp[1] = cw(4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2].exp[2] = cw(4, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[2].exp[3] = cw(4, 5, 1, 14, 1, 0, 0, 0, 1, 0, 0);
    vecs[2].exp[4] = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    set_vec(3, 7'd4, 5'd9, 5'd3, 5'd1, 3, 1);
    vecs[3].exp[1] = cw(0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0);
    vecs[3].exp[2] = cw(0, 0, 1, 1, 2, 9, 0, 1, 0, 0, 0);
    vecs[3].exp[3] = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    set_vec(4, 7'h7F, 5'd1, 5'd2, 5'd3, 1, 0);
    vecs[4].exp[1] = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    set_vec(5, 7'd0, 5'd8, 5'd9, 5'd11, 0, 0);
    set_vec(6, 7'd2, 5'd31, 5'd31, 5'd0, 4, 1);
    vecs[6].exp[1] = cw(31, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6].exp[2] = cw(31, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6].exp[3] = cw(31, 31, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[6].exp[4] = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    set_vec(7, 7'd5, 5'd6, 5'd7, 5'd8, 1, 0);
    vecs[7].exp[1] = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    dsi.instr_valid = 1'b0; dsi.op_code = '0; dsi.rs1 = '0; dsi.rs2 = '0; dsi.rd = '0;
    wsi.instr_valid = 1'b0; wsi.op_code = '0; wsi.rs1 = '0; wsi.rs2 = '0; wsi.rd = '0;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'(act), 32'(0));
    chk("reset_count", 32'(retired_count), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(dsi.instr_ready), 32'(1));
    drive(0);

    // Table: next instruction is driven while the current one is busy and
    // is accepted at the first IDLE edge after DONE.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      for (int k = 1; k <= vecs[i].lat + 1; k++) begin
        @(negedge clk);
        if (k <= vecs[i].lat) begin
          chk($sformatf("v%0d_cyc%0d_ctrl", i, k), 32'(act), 32'(vecs[i].exp[k]));
          chk($sformatf("v%0d_cyc%0d_ready", i, k), 32'(dsi.instr_ready), 32'(0));
        end else begin
          exp_count += vecs[i].legal;
          chk($sformatf("v%0d_idle_ctrl", i), 32'(act), 32'(0));
          chk($sformatf("v%0d_idle_ready", i), 32'(dsi.instr_ready), 32'(1));
          chk($sformatf("v%0d_count", i), 32'(retired_count), 32'(exp_count));
        end
        if (k == 1) drive(i + 1);
      end
    end

    // Reset in the middle of an add while in EXECUTE.
    dsi.instr_valid = 1'b1; dsi.op_code = 7'd2; dsi.rs1 = 5'd1; dsi.rs2 = 5'd2; dsi.rd = 5'd3;
    @(posedge clk);
    @(negedge clk);
    dsi.instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_execute", 32'(act), 32'(cw(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_write_en", 32'(rf_write_en), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_count", 32'(retired_count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(dsi.instr_ready), 32'(1));
    chk("abort_idle_ctrl", 32'(act), 32'(0));
    @(negedge clk);
    chk("abort_no_write", 32'(act), 32'(0));

    // Two-bit counter wraps after four back-to-back adds.
    wsi.instr_valid = 1'b1; wsi.op_code = 7'd2; wsi.rs1 = 5'd1; wsi.rs2 = 5'd1; wsi.rd = 5'd2;
    for (int n = 1; n <= 4; n++) begin
      int c;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!w_done && c < 20);
      chk($sformatf("wrap_done_%0d", n), 32'(w_done), 32'(1));
      if (n == 4) wsi.instr_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("wrap_count_%0d", n), 32'(w_count), 32'(n % 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
